// File: rtl/id_stage.sv
// id_stage: instruction decode with a one-deep registered output stage,
// load-use hazard stalling and halt tracking.
module id_stage #(
  parameter int DATA_W    = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_imm,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2,
  output logic [3:0]        out_dst,
  output logic              out_reg_write,
  output logic              out_alu_src1,
  output logic              out_alu_src2,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              out_halt,
  output logic              halted
);
  logic [3:0] op, rd, rs, rt, ld_rd, src1, src2;
  logic [DATA_W-1:0] imm;
  logic ld_pend, use_rs, use_rt, use_rd, stall, accept, lw_acc;
  logic reg_write, alu_src1, alu_src2;
  assign op = in_instr[15:12];
  assign rd = in_instr[11:8];
  assign rs = in_instr[7:4];
  assign rt = in_instr[3:0];
  always_comb begin
    use_rs = op <= 4'h9 || op == 4'hD;
    use_rt = op <= 4'h3 || op == 4'h7;
    use_rd = op inside {4'h9, 4'hA, 4'hB};
    imm = op inside {4'h4, 4'h5, 4'h6} ? DATA_W'(in_instr[3:0]) :
          op inside {4'h8, 4'h9} ? {{(DATA_W-5){in_instr[3]}}, in_instr[3:0], 1'b0} :
          op == 4'hA ? DATA_W'(in_instr[7:0]) :
          op == 4'hB ? DATA_W'({in_instr[7:0], 8'h00}) :
          op == 4'hC ? {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0} : '0;
    src1 = op inside {4'hA, 4'hB} ? rd : rs;
    src2 = op == 4'h9 ? rd : op >= 4'hC ? 4'h0 : rt;
    reg_write = op <= 4'h8 || op inside {4'hA, 4'hB, 4'hE};
    alu_src1 = op inside {4'hC, 4'hE};
    alu_src2 = op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
  end
  // R0 is hard-wired zero, so a pending load to it can never create a hazard
  assign stall = (HAZARD_EN != 0) && ld_pend && in_valid && ld_rd != 4'h0 &&
                 ((use_rs && rs == ld_rd) || (use_rt && rt == ld_rd) || (use_rd && rd == ld_rd));
  assign in_ready = (~out_valid | out_ready) & ~stall & ~flush & ~halted;
  assign accept = in_valid & in_ready;
  assign lw_acc = accept && op == 4'h8 && rd != 4'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      ld_pend        <= 1'b0;
      ld_rd          <= '0;
      halted         <= 1'b0;
      out_opcode     <= '0;
      out_pc         <= '0;
      out_imm        <= '0;
      out_src1       <= '0;
      out_src2       <= '0;
      out_dst        <= '0;
      out_reg_write  <= 1'b0;
      out_alu_src1   <= 1'b0;
      out_alu_src2   <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_halt       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ld_pend   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid      <= 1'b1;
        out_opcode     <= op;
        out_pc         <= in_pc;
        out_imm        <= imm;
        out_src1       <= src1;
        out_src2       <= src2;
        out_dst        <= rd;
        out_reg_write  <= reg_write;
        out_alu_src1   <= alu_src1;
        out_alu_src2   <= alu_src2;
        out_mem_read   <= op == 4'h8;
        out_mem_write  <= op == 4'h9;
        out_mem_to_reg <= op == 4'h8;
        out_halt       <= op == 4'hF;
        if (op == 4'hF) halted <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (lw_acc) begin
        ld_pend <= 1'b1;
        ld_rd   <= rd;
      end else if (out_ready) begin
        ld_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed checks of id_stage against a
// table-driven decode model and a transaction-level pipeline model.
module tb_id_stage;
  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [3:0]  s1, s2, dst;
    logic        rw, a1, a2, mr, mw, m2r, h;
  } bundle_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid, halted;
  logic [3:0] out_opcode, out_src1, out_src2, out_dst;
  logic [15:0] out_pc, out_imm;
  logic out_reg_write, out_alu_src1, out_alu_src2, out_mem_read, out_mem_write, out_mem_to_reg, out_halt;
  logic w_in_ready, w_out_valid, w_halted;
  logic [3:0] w_opcode, w_src1, w_src2, w_dst;
  logic [31:0] w_pc, w_imm;
  logic w_rw, w_a1, w_a2, w_mr, w_mw, w_m2r, w_h;
  bundle_t obs, m_b;
  logic m_valid, m_ld_pend, m_halted;
  logic [3:0] m_ld_rd;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(16), .HAZARD_EN(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_pc(out_pc), .out_imm(out_imm), .out_src1(out_src1),
    .out_src2(out_src2), .out_dst(out_dst), .out_reg_write(out_reg_write),
    .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_halt(out_halt),
    .halted(halted));

  id_stage #(.DATA_W(32), .HAZARD_EN(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
    .in_pc({16'h0, in_pc}), .flush(flush), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_opcode(w_opcode), .out_pc(w_pc), .out_imm(w_imm), .out_src1(w_src1),
    .out_src2(w_src2), .out_dst(w_dst), .out_reg_write(w_rw), .out_alu_src1(w_a1),
    .out_alu_src2(w_a2), .out_mem_read(w_mr), .out_mem_write(w_mw), .out_mem_to_reg(w_m2r),
    .out_halt(w_h), .halted(w_halted));

  assign obs = {out_opcode, out_pc, out_imm, out_src1, out_src2, out_dst, out_reg_write,
                out_alu_src1, out_alu_src2, out_mem_read, out_mem_write, out_mem_to_reg, out_halt};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bundle_t decode(input logic [15:0] i, input logic [15:0] p);
    bundle_t b = '0;
    b.op = i[15:12]; b.pc = p; b.dst = i[11:8]; b.s1 = i[7:4]; b.s2 = i[3:0];
    case (i[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: b.rw = 1;
      4'h4, 4'h5, 4'h6: begin b.rw = 1; b.a2 = 1; b.imm = {12'h0, i[3:0]}; end
      4'h8: begin b.rw = 1; b.a2 = 1; b.mr = 1; b.m2r = 1; b.imm = {{11{i[3]}}, i[3:0], 1'b0}; end
      4'h9: begin b.a2 = 1; b.mw = 1; b.s2 = i[11:8]; b.imm = {{11{i[3]}}, i[3:0], 1'b0}; end
      4'hA: begin b.rw = 1; b.a2 = 1; b.s1 = i[11:8]; b.imm = {8'h0, i[7:0]}; end
      4'hB: begin b.rw = 1; b.a2 = 1; b.s1 = i[11:8]; b.imm = {i[7:0], 8'h0}; end
      4'hC: begin b.a1 = 1; b.a2 = 1; b.s2 = 0; b.imm = {{6{i[8]}}, i[8:0], 1'b0}; end
      4'hD: b.s2 = 0;
      4'hE: begin b.rw = 1; b.a1 = 1; b.a2 = 1; b.s2 = 0; end
      default: begin b.h = 1; b.s2 = 0; end
    endcase
    return b;
  endfunction

  function automatic logic reads(input logic [15:0] i, input logic [3:0] r);
    int op = int'(i[15:12]);
    if (r == 0) return 0;
    return ((op <= 9 || op == 13) && i[7:4] == r) ||
           ((op <= 3 || op == 7) && i[3:0] == r) ||
           (op >= 9 && op <= 11 && i[11:8] == r);
  endfunction

  task automatic step(input logic v, input logic [15:0] i, input logic [15:0] p,
                      input logic ordy, input logic fl);
    logic exp_rdy, acc;
    in_valid = v; in_instr = i; in_pc = p; out_ready = ordy; flush = fl;
    #2;
    exp_rdy = (!m_valid || ordy) && !(v && m_ld_pend && reads(i, m_ld_rd)) && !fl && !m_halted;
    check("in_ready", {63'h0, in_ready}, {63'h0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (fl) begin
      m_valid = 0; m_ld_pend = 0;
    end else begin
      if (acc) begin
        m_b = decode(i, p); m_valid = 1;
        if (i[15:12] == 4'hF) m_halted = 1;
      end else if (ordy) m_valid = 0;
      if (acc && i[15:12] == 4'h8 && i[11:8] != 0) begin
        m_ld_pend = 1; m_ld_rd = i[11:8];
      end else if (ordy) m_ld_pend = 0;
    end
    #1;
    check("out_valid", {63'h0, out_valid}, {63'h0, m_valid});
    check("bundle", 64'(obs), 64'(m_b));
    check("halted", {63'h0, halted}, {63'h0, m_halted});
  endtask

  task automatic pulse_rst();
    in_valid = 0; flush = 0;
    rst = 1;
    #2;
    m_valid = 0; m_ld_pend = 0; m_ld_rd = 0; m_halted = 0; m_b = '0;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_halted", {63'h0, halted}, 64'h0);
    check("rst_bundle", 64'(obs), 64'h0);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ins;
    @(posedge clk);
    #1;
    pulse_rst();
    step(1, 16'h0123, 16'h0002, 1, 0);
    step(1, 16'h1456, 16'h0004, 1, 0);
    step(1, 16'h4A23, 16'h0006, 1, 0);
    check("imm_4A23", 64'(out_imm), 64'h0003);
    check("alu_src2_4A23", {63'h0, out_alu_src2}, 64'h1);
    pulse_rst();
    step(1, 16'h8312, 16'h0010, 1, 0);
    step(1, 16'h0534, 16'h0012, 1, 0);
    check("lw_bubble", {63'h0, out_valid}, 64'h0);
    check("nohaz_valid", {63'h0, w_out_valid}, 64'h1);
    check("nohaz_op", 64'(w_opcode), 64'h0);
    step(1, 16'h0534, 16'h0012, 1, 0);
    check("add_after_bubble", {63'h0, out_valid}, 64'h1);
    step(1, 16'h8012, 16'h0020, 1, 0);
    step(1, 16'h0100, 16'h0022, 1, 0);
    check("r0_no_bubble", {63'h0, out_valid}, 64'h1);
    pulse_rst();
    step(1, 16'hC1FF, 16'h0030, 1, 0);
    check("imm_C1FF_16", 64'(out_imm), 64'hFFFE);
    check("imm_C1FF_32", 64'(w_imm), 64'hFFFF_FFFE);
    step(1, 16'hB2AB, 16'h0032, 1, 0);
    check("imm_B2AB", 64'(out_imm), 64'hAB00);
    step(1, 16'h0123, 16'h0040, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 16'h2222, 16'h0042, 0, 0);
      check("hold_op", 64'(out_opcode), 64'h0);
    end
    step(1, 16'h2222, 16'h0042, 0, 1);
    check("flush_valid", {63'h0, out_valid}, 64'h0);
    step(1, 16'hF000, 16'h0050, 1, 0);
    check("hlt_out_halt", {63'h0, out_halt}, 64'h1);
    check("hlt_halted", {63'h0, halted}, 64'h1);
    step(1, 16'h0123, 16'h0052, 1, 0);
    step(1, 16'h0123, 16'h0054, 0, 0);
    pulse_rst();
    for (int n = 0; n < 600; n++) begin
      if (m_halted || $urandom_range(0, 39) == 0) pulse_rst();
      ins = 16'($urandom);
      ins[11:8] = 4'($urandom_range(0, 3));
      ins[7:4] = 4'($urandom_range(0, 3));
      if (ins[15:12] == 4'hF && $urandom_range(0, 3) != 0) ins[15:12] = 4'h8;
      step($urandom_range(0, 3) != 0, ins, 16'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning datapath/immediate width (legal values >= 16).
REQ-002 The block SHALL have parameter HAZARD_EN, default 1, meaning load-use stall logic enabled (0 = never stall for hazards).
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  fetch presents an instruction.
REQ-006 Port in_ready  output  1  block accepts the instruction this cycle.
REQ-007 Port in_instr  input  16  instruction word; opcode = in_instr[15:12], rd = [11:8], rs = [7:4], rt = [3:0].
REQ-008 Port in_pc  input  DATA_W  PC+2 of the instruction.
REQ-009 Port flush  input  1  discard all held state (taken branch).
REQ-010 Port out_valid  output  1  decoded bundle valid.
REQ-011 Port out_ready  input  1  execute stage consumes bundle.
REQ-012 Port out_opcode  output  4; out_pc  output  DATA_W; out_imm  output  DATA_W.
REQ-013 Port out_src1, out_src2, out_dst  output  4 each  register file addresses.
REQ-014 Port out_reg_write, out_alu_src1, out_alu_src2, out_mem_read, out_mem_write, out_mem_to_reg, out_halt  output  1 each  control flags.
REQ-015 Port halted  output  1  HLT accepted; fetch frozen.

Function
REQ-016 Handshake: transfer in on in_valid & in_ready; transfer out on out_valid & out_ready; one registered output stage, latency exactly 1 cycle from accept to out_valid.
REQ-017 in_ready = (~out_valid | out_ready) & ~stall & ~flush & ~halted.
REQ-018 Output bundle SHALL hold stable while out_valid & ~out_ready.
REQ-019 Accept cycle: out_* registered from decode of in_instr, out_valid <= 1; out-transfer without accept: out_valid <= 0 (bubble).
REQ-020 Immediates, sign/zero-extended to DATA_W: 0100-0110 zero-extended [3:0]; 1000/1001 sign-extended [3:0]<<1; 1010 zero-extended [7:0]; 1011 [7:0] in bits [15:8], other bits 0; 1100 sign-extended [8:0]<<1; others 0.
REQ-021 out_src1 = rd for 1010/1011, else rs; out_src2 = rd for 1001, 0 for 1100-1111, else rt; out_dst = rd.
REQ-022 out_reg_write = 1 for 0000-0111, 1000, 1010, 1011, 1110; else 0.
REQ-023 out_mem_read = out_mem_to_reg = (op==1000); out_mem_write = (op==1001); out_halt = (op==1111).
REQ-024 out_alu_src1 = 1 (PC) for 1100, 1110; out_alu_src2 = 1 (imm) for 0100-0110, 1000-1011, 1100, 1110.
REQ-025 Source-use flags: rs read by 0000-1001, 1101; rt read by 0000-0011, 0111; rd read by 1001-1011.
REQ-026 Load tracking: register ld_pend/ld_rd; set ld_pend=1, ld_rd=rd on accept of 1000 with rd!=0.
REQ-027 ld_pend clears at end of any cycle with out_ready=1 and no LW accepted; otherwise holds.
REQ-028 stall = HAZARD_EN & ld_pend & in_valid & incoming instruction reads a register (per REQ-025) equal to ld_rd; R0 never hazards.
REQ-029 Result: dependent instruction directly after LW sees exactly one bubble when out_ready stays 1; longer if out_ready low.
REQ-030 flush (synchronous, highest priority): next cycle out_valid=0, ld_pend=0; no accept in flush cycle; halted unaffected.
REQ-031 halted set on accept of 1111, cleared only by reset; HLT bundle still delivered downstream.
REQ-032 Simultaneous out-transfer and accept SHALL sustain one instruction per cycle with no bubble.

Reset
REQ-033 On rst high, asynchronously: out_valid=0, ld_pend=0, ld_rd=0, halted=0, all out_* data/control registers = 0.
REQ-034 Reset mid-stall or mid-hold SHALL discard the held bundle; in_ready=1 first cycle after rst deasserts if in_valid and no hazard.

Verification
REQ-035 Stream 0x0123 (ADD), 0x1456, 0x4A23 with out_ready=1 -> out_valid each cycle from cycle 1, out_imm for 0x4A23 = 0x0003, out_alu_src2=1.
REQ-036 LW 0x8312 (rd=3) then ADD 0x0534 (rs=3) -> one bubble (out_valid=0) between; ADD out one cycle later; HAZARD_EN=0 -> no bubble.
REQ-037 LW rd=0 (0x8012) then ADD reading R0 -> no bubble.
REQ-038 Branch 0xC1FF -> out_imm = sign-extended 0x1FF<<1 = 0xFFFE (DATA_W=16), 0xFFFFFFFE (DATA_W=32); 0xB2AB -> out_imm = 0xAB00.
REQ-039 out_ready=0 for 3 cycles with bundle held -> in_ready=0, bundle stable; flush asserted during hold -> out_valid=0 next cycle.
REQ-040 HLT 0xF000 accepted -> out_halt=1 next cycle, halted=1, in_ready stays 0; rst pulse mid-cycle -> halted=0, out_valid=0 immediately.
